seg7_scan4: RTL and testbench
=============================

# seg7_scan4

Four-digit multiplexed 7-segment display driver. It sits directly downstream of the counter/FIFO core and feeds the board's `ss`/`dig` pins. It accepts 16-bit values through a write strobe and holds them in a pending register. A new value is committed only at a frame boundary, so a digit never shows half of an old value and half of a new one. It scans the four digits at a programmable rate, gated by an upstream enable, with hex decode and leading-zero blanking.

## Interface
- `SCAN_DIV`, 10000: enabled clk cycles per digit slot; legal range ≥ 2.
- `SEG_ACT_LOW`, 1: 1 = segment lit when its bit is 0.
- `DIG_ACT_LOW`, 1: 1 = digit selected when its bit is 0.
- `BLANK_LZ`, 1: 1 = blank leading zero digits.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `en`  in  1  scan enable (e.g. `ENwrk` from `cnt_div`).
- `wr`  in  1  single-cycle load strobe for `data`.
- `data`  in  16  value to display; [15:12] → `dig[1]` (leftmost), [3:0] → `dig[4]`.
- `ss`  out  7  segments; `ss[0]`=a … `ss[6]`=g; registered.
- `dig`  out  4  `dig[4:1]` one-hot digit select at active level; registered.
- `pend`  out  1  a written value is waiting for the next frame boundary.
- `frame`  out  1  one-cycle pulse when the scan wraps from digit 4 to digit 1.

## Operation
- **Divider** `div_cnt`:
  - Counts 0..SCAN_DIV-1 only while `en`=1 and wraps to 0.
  - `tick` = `en` & (`div_cnt`==SCAN_DIV-1).
- **Scan index** `idx` (0..3, 0 ↔ `dig[1]`): advances on `tick`; 3 → 0 wraps, and that wrap asserts `frame` in the same cycle as the wrap's register update.
- **Pending register**:
  - `wr`=1 → `pend_val`<=`data`, `pend`<=1.
  - A second `wr` before the boundary overwrites; only the last value counts.
- **Commit**: on `tick` with `idx`==3:
  - If `wr`=1 that cycle, `disp_val`<=`data` and `pend`<=0 (the strobe wins, with no extra frame of delay).
  - Else if `pend`=1, `disp_val`<=`pend_val` and `pend`<=0.
  - Otherwise `disp_val` holds.
- **Decode**:
  - The nibble `disp_val[15-4*idx -: 4]` is mapped to segments; active-low values for 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex; b and d lowercase).
  - If `SEG_ACT_LOW`=0, the value is bit-inverted.
- **Blanking** (`BLANK_LZ`=1):
  - Digit k (1..3) is blanked when it and every digit to its left are 0.
  - `dig[4]` is never blanked.
  - A blanked digit still gets its `dig` strobe, with `ss` at the all-off level.
- **`dig`**: exactly one digit active at all times after reset; inversion is per `DIG_ACT_LOW`.
- **`en`=0**: `div_cnt`, `idx`, `ss` and `dig` freeze; `wr` is still accepted into the pending register; no commit happens.

## Timing
- **Reset** (`rst_n`=0 at a clk edge):
  - `div_cnt`=0, `idx`=0, `disp_val`=0, `pend_val`=0, `pend`=0, `frame`=0.
  - `ss` = all off (7'h7F for active-low), `dig` = none selected (4'hF for active-low).
  - Reset mid-frame discards any pending value.
- **First edge after release**: `dig[1]` selected (4'hE), `ss` off (blanked zero).
- **Outputs**: `ss`/`dig` are registered from `idx`/`disp_val`, lagging `idx` by 1 cycle.
- **Digit slot**: SCAN_DIV enabled cycles; frame = 4·SCAN_DIV enabled cycles.
- **Write-to-display latency**: commit at the next `idx`==3 `tick`; `dig[1]` shows the new value 1 cycle later. Worst case is 4·SCAN_DIV+1 enabled cycles.
- **`pend`**: asserted the cycle after `wr`; cleared the cycle after commit.

## Test plan
- **Reset**: reset, SCAN_DIV=4, `en`=1, no writes → `dig` cycles E,D,B,7 every 4 clocks; `ss`=7F for digits 1-3 and 40 on digit 4; `frame` pulses every 16 clocks.
- **Hex decode**: write 16'h1A2F, wait one frame → `ss` sequence 79,08,24,0E on `dig` E,D,B,7.
- **Blanking**: write 16'h0030 → digits 1-2 off (7F), digit 3 = 30, digit 4 = 40. Write 16'h0000 → only digit 4 lit (40).
- **No tearing**: write 16'h1111 mid-frame, then 16'h2222 before the boundary → no slot ever shows 79 and 24 in the same frame; `pend`=1 until the boundary, then 0; every digit shows 24.
- **Simultaneous write at the boundary**: `wr` of 16'h8888 in the same cycle as the `idx`==3 `tick` → the next frame shows 00 on all digits and `pend` stays 0.
- **Enable and reset**: hold `en`=0 for 50 cycles → `ss`/`dig` constant, no `frame`; a `wr` sets `pend`. Then assert `rst_n`=0 for 1 cycle → `pend`=0, `ss`=7F, `dig`=F, and the next frame displays 0.

Source files
------------

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment driver: hex decode, leading-zero blanking,
// and a pending register that commits new values only at frame boundaries.
module seg7_scan4 #(
    parameter int SCAN_DIV    = 10000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr,
    input  logic [15:0] data,
    output logic [6:0]  ss,
    output logic [4:1]  dig,
    output logic        pend,
    output logic        frame
);

    localparam int                 DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]         SS_OFF  = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]         DIG_OFF = DIG_ACT_LOW ? 4'hF : 4'h0;

    // Active-low segment pattern (bit0 = a ... bit6 = g) for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_val_q, disp_val_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             frame_q, frame_d;
    logic [6:0]       ss_q, ss_d;
    logic [4:1]       dig_q, dig_d;

    logic             tick_s;
    logic             boundary_s;
    logic [3:0]       nib_s;
    logic             lead_zero_s;
    logic [6:0]       seg_raw_s;
    logic [3:0]       dig_raw_s;

    // Next-state logic for the divider, scan index, pending/commit path and outputs.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        idx_d      = idx_q;
        disp_val_d = disp_val_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;

        tick_s     = en && (div_cnt_q == DIV_MAX);
        boundary_s = tick_s && (idx_q == 2'd3);
        frame_d    = boundary_s;

        if (tick_s) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end else if (en) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q;
        end

        if (wr) begin
            pend_val_d = data;
        end else begin
            pend_val_d = pend_val_q;
        end

        // A strobe landing on the boundary itself goes straight to the display.
        if (boundary_s) begin
            pend_d = 1'b0;
            if (wr) begin
                disp_val_d = data;
            end else if (pend_q) begin
                disp_val_d = pend_val_q;
            end else begin
                disp_val_d = disp_val_q;
            end
        end else if (wr) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (idx_q)
            2'd0: begin
                nib_s       = disp_val_q[15:12];
                lead_zero_s = (disp_val_q[15:12] == 4'h0);
            end
            2'd1: begin
                nib_s       = disp_val_q[11:8];
                lead_zero_s = (disp_val_q[15:8] == 8'h00);
            end
            2'd2: begin
                nib_s       = disp_val_q[7:4];
                lead_zero_s = (disp_val_q[15:4] == 12'h000);
            end
            default: begin
                nib_s       = disp_val_q[3:0];
                lead_zero_s = 1'b0;
            end
        endcase

        if (BLANK_LZ && lead_zero_s) begin
            seg_raw_s = 7'h7F;
        end else begin
            seg_raw_s = hex_to_seg(nib_s);
        end
        ss_d      = SEG_ACT_LOW ? seg_raw_s : ~seg_raw_s;
        dig_raw_s = 4'b0001 << idx_q;
        dig_d     = DIG_ACT_LOW ? ~dig_raw_s : dig_raw_s;
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            idx_q      <= 2'd0;
            disp_val_q <= 16'h0000;
            pend_val_q <= 16'h0000;
            pend_q     <= 1'b0;
            frame_q    <= 1'b0;
            ss_q       <= SS_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            frame_q    <= frame_d;
            ss_q       <= ss_d;
            dig_q      <= dig_d;
        end
    end

    assign ss    = ss_q;
    assign dig   = dig_q;
    assign pend  = pend_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboarded random/directed bench for seg7_scan4 with SCAN_DIV=4.
module tb_seg7_scan4;

    localparam int D = 4;
    localparam int FRAME_LEN = 4 * D;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [6:0]  ss;
    logic [4:1]  dig;
    logic        pend;
    logic        frame;

    typedef struct packed {
        logic [6:0] ss;
        logic [3:0] dig;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: enabled cycles into the current frame, shown and pending values.
    int          m_n = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pv = 16'h0000;
    bit          m_pend = 1'b0;

    seg7_scan4 #(
        .SCAN_DIV(D), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .data(data),
        .ss(ss), .dig(dig), .pend(pend), .frame(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_ss(input logic [15:0] v, input int slot);
        logic [15:0] lead;
        lead = v >> (4 * (3 - slot));
        if (slot < 3 && lead == 16'h0000) return 7'h7F;
        return SEG_TAB[lead[3:0]];
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   slot;
        bit   boundary;
        logic [3:0] onehot;
        if (!rst_n) begin
            m_n = 0; m_disp = 16'h0000; m_pv = 16'h0000; m_pend = 1'b0;
            e = '{ss: 7'h7F, dig: 4'hF, pend: 1'b0, frame: 1'b0};
        end else begin
            slot     = m_n / D;
            boundary = en && (m_n == FRAME_LEN - 1);
            onehot   = 4'b0001 << slot;
            e.ss     = exp_ss(m_disp, slot);
            e.dig    = ~onehot;
            if (boundary) begin
                m_disp = wr ? data : (m_pend ? m_pv : m_disp);
                m_pend = 1'b0;
            end else if (wr) begin
                m_pend = 1'b1;
            end
            if (wr) m_pv = data;
            if (en) m_n = (m_n + 1) % FRAME_LEN;
            e.pend  = m_pend;
            e.frame = boundary;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ss !== e.ss || dig !== e.dig || pend !== e.pend || frame !== e.frame) begin
                errors++;
                $display("FAIL outputs t=%0t: got ss=%h dig=%h pend=%b frame=%b, expected ss=%h dig=%h pend=%b frame=%b",
                         $time, ss, dig, pend, frame, e.ss, e.dig, e.pend, e.frame);
            end
        end
    end

    task automatic cyc(input bit r, input bit e, input bit w, input logic [15:0] d);
        rst_n = r; en = e; wr = w; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    // Advance with en=1 until the model's frame position equals ph (so a strobe lands there).
    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (m_n != ph && k < 100) begin
            cyc(1'b1, 1'b1, 1'b0, 16'h0000);
            k++;
        end
        if (m_n != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: position %0d, wanted %0d", m_n, ph);
        end
    endtask

    initial begin
        logic [15:0] rd;
        bit r, e, w;
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        idle(40);
        wait_phase(3);
        cyc(1'b1, 1'b1, 1'b1, 16'h1A2F);
        idle(40);
        cyc(1'b1, 1'b1, 1'b1, 16'h0030);
        idle(40);
        cyc(1'b1, 1'b1, 1'b1, 16'h0000);
        idle(40);
        wait_phase(5);
        cyc(1'b1, 1'b1, 1'b1, 16'h1111);
        idle(3);
        cyc(1'b1, 1'b1, 1'b1, 16'h2222);
        idle(40);
        wait_phase(FRAME_LEN - 1);
        cyc(1'b1, 1'b1, 1'b1, 16'h8888);
        idle(20);
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, (i == 20), 16'h5A5A);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        idle(40);
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom % 400) != 0;
            e  = ($urandom % 8) != 0;
            w  = (m_n == FRAME_LEN - 1) ? ($urandom % 2 == 0) : ($urandom % 12 == 0);
            rd = 16'($urandom);
            rd = rd >> ($urandom % 16);
            cyc(r, e, w, rd);
        end
        idle(5);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
